// File: rtl/airi5c_dmi_arbiter.sv
// airi5c_dmi_arbiter
// Shares the single DMI bus between two debug requesters (port 0: JTAG DTM,
// port 1: secondary debug bridge). Each port hands over one-cycle request
// pulses that are latched into a one-deep slot. Slots are granted round-robin
// and exactly one DMI transaction is in flight at a time. After the Debug
// Module drops dmi_dm_busy, the response goes back to the granted port.
//
// Optional build macro: AIRI5C_DMI_ARB_TIMEOUT_EN
//   When defined, a WAIT that sees dmi_dm_busy high for TIMEOUT_CYCLES cycles
//   is forced to complete with rdata=0 and error=1.
//   When undefined, WAIT is unbounded.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   mX_en/wen/addr/wdata           request pulse plus qualifiers (X = 0, 1)
//   mX_rdata/error                 response, held until the next response
//   mX_rsp_valid, mX_overrun       one-cycle pulses: response updated / request dropped
//   mX_busy                        request pending or in service
//   dmi_addr/wdata/en/wen          transaction towards the Debug Module
//   dmi_rdata/error/dm_busy        response from the Debug Module
module airi5c_dmi_arbiter #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_en,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_error,
  output logic              m0_rsp_valid,
  output logic              m0_busy,
  output logic              m0_overrun,
  input  logic              m1_en,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_error,
  output logic              m1_rsp_valid,
  output logic              m1_busy,
  output logic              m1_overrun,
  output logic [ADDR_W-1:0] dmi_addr,
  output logic [DATA_W-1:0] dmi_wdata,
  output logic              dmi_en,
  output logic              dmi_wen,
  input  logic [DATA_W-1:0] dmi_rdata,
  input  logic              dmi_error,
  input  logic              dmi_dm_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                   state, state_nxt;
  logic                     gnt, gnt_nxt;   // port owning the current transaction
  logic                     ptr;            // port favoured when both are pending
  logic                     grant_vld, grant_port, rsp_take, timeout_hit;
  logic [1:0]               en, in_wen, pend, pend_nxt, acc, drop, in_svc, busy_nxt;
  logic [1:0][ADDR_W-1:0]   in_addr, req_addr;
  logic [1:0][DATA_W-1:0]   in_wdata, req_wdata, rsp_rdata;
  logic [1:0]               req_wen, rsp_error, rsp_valid, busy, overrun;

  assign en       = {m1_en, m0_en};
  assign in_wen   = {m1_wen, m0_wen};
  assign in_addr  = {m1_addr, m0_addr};
  assign in_wdata = {m1_wdata, m0_wdata};

`ifdef AIRI5C_DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  // Counter holds the number of busy WAIT cycles already seen, so the
  // TIMEOUT_CYCLES-th busy cycle is the one that forces the response.
  assign timeout_hit = dmi_dm_busy && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)                             to_cnt <= '0;
    else if (state == S_ISSUE)             to_cnt <= '0;
    else if (state == S_WAIT && dmi_dm_busy) to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign rsp_take = (state == S_WAIT) && (!dmi_dm_busy || timeout_hit);

  always_comb begin
    grant_vld  = (state == S_IDLE) && (|pend);
    grant_port = (&pend) ? ptr : pend[1];
    gnt_nxt    = grant_vld ? grant_port : gnt;
    state_nxt  = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (rsp_take) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    for (int i = 0; i < 2; i++) begin
      // RESP is not "in service": a port may re-request alongside its rsp_valid.
      in_svc[i]   = (gnt == 1'(i)) && (state == S_ISSUE || state == S_WAIT);
      acc[i]      = en[i] & ~pend[i] & ~in_svc[i];
      drop[i]     = en[i] & ~acc[i];
      pend_nxt[i] = acc[i] | (pend[i] & ~(grant_vld && grant_port == 1'(i)));
      busy_nxt[i] = pend_nxt[i] | ((gnt_nxt == 1'(i)) && (state_nxt != S_IDLE));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt       <= 1'b0;
      ptr       <= 1'b0;
      pend      <= '0;
      req_wen   <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      dmi_addr  <= '0;
      dmi_wdata <= '0;
      dmi_en    <= 1'b0;
      dmi_wen   <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= '0;
      rsp_valid <= '0;
      busy      <= '0;
      overrun   <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      pend    <= pend_nxt;
      busy    <= busy_nxt;
      overrun <= drop;
      // Strobes are loaded on the grant so they are high exactly in ISSUE.
      dmi_en  <= grant_vld;
      dmi_wen <= grant_vld & req_wen[grant_port];
      if (grant_vld) begin
        dmi_addr  <= req_addr[grant_port];
        dmi_wdata <= req_wdata[grant_port];
        // Pointer only moves on a contested grant, so a lone request does
        // not steal the next tie from the other port.
        if (&pend) ptr <= ~grant_port;
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          req_wen[i]   <= in_wen[i];
          req_addr[i]  <= in_addr[i];
          req_wdata[i] <= in_wdata[i];
        end
      end
      rsp_valid <= '0;
      if (rsp_take) begin
        rsp_valid[gnt] <= 1'b1;
        rsp_rdata[gnt] <= timeout_hit ? '0 : dmi_rdata;
        rsp_error[gnt] <= timeout_hit | dmi_error;
      end
    end
  end

  assign m0_rdata     = rsp_rdata[0];
  assign m0_error     = rsp_error[0];
  assign m0_rsp_valid = rsp_valid[0];
  assign m0_busy      = busy[0];
  assign m0_overrun   = overrun[0];
  assign m1_rdata     = rsp_rdata[1];
  assign m1_error     = rsp_error[1];
  assign m1_rsp_valid = rsp_valid[1];
  assign m1_busy      = busy[1];
  assign m1_overrun   = overrun[1];

endmodule

// File: tb/tb_airi5c_dmi_arbiter.sv
// Self-checking bench for airi5c_dmi_arbiter: transaction-level reference
// model compared on every cycle, directed scenarios with literal
// expectations, then randomized traffic with occasional resets.
module tb_airi5c_dmi_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_en, m0_wen, m1_en, m1_wen;
  logic [AW-1:0] m0_addr, m1_addr, dmi_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, dmi_wdata, dmi_rdata;
  logic          m0_error, m0_rsp_valid, m0_busy, m0_overrun;
  logic          m1_error, m1_rsp_valid, m1_busy, m1_overrun;
  logic          dmi_en, dmi_wen, dmi_error, dmi_dm_busy;

  always #5 clk = ~clk;

  airi5c_dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_en(m0_en), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_error(m0_error), .m0_rsp_valid(m0_rsp_valid),
    .m0_busy(m0_busy), .m0_overrun(m0_overrun),
    .m1_en(m1_en), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_error(m1_error), .m1_rsp_valid(m1_rsp_valid),
    .m1_busy(m1_busy), .m1_overrun(m1_overrun),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_en(dmi_en), .dmi_wen(dmi_wen),
    .dmi_rdata(dmi_rdata), .dmi_error(dmi_error), .dmi_dm_busy(dmi_dm_busy)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one-deep mailbox per port, one transaction in flight
  bit            has[2];
  logic [AW-1:0] s_addr[2];
  logic [DW-1:0] s_wdata[2];
  bit            s_wen[2];
  int            phase;      // 0 idle, 1 issued, 2 waiting, 3 responding
  int            cport;
  bit            favour;
  int            waited;

  logic [AW-1:0] e_daddr;
  logic [DW-1:0] e_dwdata;
  bit            e_den, e_dwen;
  logic [DW-1:0] e_rdata[2];
  bit            e_err[2], e_rv[2], e_busy[2], e_ovr[2];

  // observation helpers for directed tests
  logic [AW-1:0] iss[$];
  int            den_cnt, rv_cnt[2], ovr_cnt[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit en[2], ovr[2], take[2], lock;
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    bit w[2];
    int pick;
    en[0] = m0_en; en[1] = m1_en;
    a[0] = m0_addr; a[1] = m1_addr;
    d[0] = m0_wdata; d[1] = m1_wdata;
    w[0] = m0_wen; w[1] = m1_wen;
    if (reset) begin
      phase = 0; cport = 0; favour = 0; waited = 0;
      e_daddr = '0; e_dwdata = '0; e_den = 0; e_dwen = 0;
      for (int i = 0; i < 2; i++) begin
        has[i] = 0; s_addr[i] = '0; s_wdata[i] = '0; s_wen[i] = 0;
        e_rdata[i] = '0; e_err[i] = 0; e_rv[i] = 0; e_busy[i] = 0; e_ovr[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      lock    = (phase == 1 || phase == 2) && cport == i;
      ovr[i]  = en[i] && (has[i] || lock);
      take[i] = en[i] && !ovr[i];
      e_rv[i] = 0;
    end
    e_den = 0; e_dwen = 0;
    case (phase)
      0: if (has[0] || has[1]) begin
        if (has[0] && has[1]) begin
          pick = favour ? 1 : 0;
          favour = (pick == 0);
        end else pick = has[1] ? 1 : 0;
        cport = pick; has[pick] = 0;
        e_daddr = s_addr[pick]; e_dwdata = s_wdata[pick];
        e_den = 1; e_dwen = s_wen[pick];
        phase = 1;
      end
      1: begin phase = 2; waited = 0; end
      2: if (!dmi_dm_busy) begin
        e_rdata[cport] = dmi_rdata; e_err[cport] = dmi_error; e_rv[cport] = 1;
        phase = 3;
      end
`ifdef AIRI5C_DMI_ARB_TIMEOUT_EN
      else begin
        waited++;
        if (waited == TO) begin
          e_rdata[cport] = '0; e_err[cport] = 1; e_rv[cport] = 1;
          phase = 3;
        end
      end
`endif
      default: phase = 0;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (take[i]) begin
        has[i] = 1; s_addr[i] = a[i]; s_wdata[i] = d[i]; s_wen[i] = w[i];
      end
      e_ovr[i]  = ovr[i];
      e_busy[i] = has[i] || (phase != 0 && cport == i);
    end
  endtask

  task automatic compare_all();
    chk("dmi_addr", dmi_addr, e_daddr);
    chk("dmi_wdata", dmi_wdata, e_dwdata);
    chk("dmi_en", dmi_en, e_den);
    chk("dmi_wen", dmi_wen, e_dwen);
    chk("m0_rdata", m0_rdata, e_rdata[0]);
    chk("m0_error", m0_error, e_err[0]);
    chk("m0_rsp_valid", m0_rsp_valid, e_rv[0]);
    chk("m0_busy", m0_busy, e_busy[0]);
    chk("m0_overrun", m0_overrun, e_ovr[0]);
    chk("m1_rdata", m1_rdata, e_rdata[1]);
    chk("m1_error", m1_error, e_err[1]);
    chk("m1_rsp_valid", m1_rsp_valid, e_rv[1]);
    chk("m1_busy", m1_busy, e_busy[1]);
    chk("m1_overrun", m1_overrun, e_ovr[1]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dmi_addr"}, dmi_addr, 0);
    chk({tag, "_dmi_wdata"}, dmi_wdata, 0);
    chk({tag, "_dmi_en"}, dmi_en, 0);
    chk({tag, "_dmi_wen"}, dmi_wen, 0);
    chk({tag, "_m0_outs"}, {m0_rdata, m0_error, m0_rsp_valid, m0_busy, m0_overrun}, 0);
    chk({tag, "_m1_outs"}, {m1_rdata, m1_error, m1_rsp_valid, m1_busy, m1_overrun}, 0);
  endtask

  // Inputs for the current cycle are already driven; the model predicts the
  // registered outputs, the edge happens, then outputs are compared.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    if (dmi_en) begin den_cnt++; iss.push_back(dmi_addr); end
    if (m0_rsp_valid) rv_cnt[0]++;
    if (m1_rsp_valid) rv_cnt[1]++;
    if (m0_overrun) ovr_cnt[0]++;
    if (m1_overrun) ovr_cnt[1]++;
    m0_en = 0; m1_en = 0;
  endtask

  task automatic req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    if (p == 0) begin m0_en = 1; m0_addr = a; m0_wdata = d; m0_wen = w; end
    else        begin m1_en = 1; m1_addr = a; m1_wdata = d; m1_wen = w; end
  endtask

  task automatic clr_obs();
    iss.delete(); den_cnt = 0;
    rv_cnt[0] = 0; rv_cnt[1] = 0; ovr_cnt[0] = 0; ovr_cnt[1] = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  initial begin
    reset = 1; m0_en = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0;
    m1_en = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0;
    dmi_rdata = '0; dmi_error = 0; dmi_dm_busy = 0;
    clr_obs();
    @(negedge clk);
    tick(); tick();
    chk_all_zero("reset");
    reset = 0;

    // single read, minimum latency
    clr_obs();
    dmi_rdata = 32'hDEADBEEF; dmi_error = 0; dmi_dm_busy = 0;
    req(0, 7'h11, 32'h0, 1'b0);
    tick();                                       // t+1
    chk("rd_busy_t1", m0_busy, 1);
    tick();                                       // t+2
    chk("rd_den_t2", dmi_en, 1);
    chk("rd_addr_t2", dmi_addr, 7'h11);
    chk("rd_wen_t2", dmi_wen, 0);
    tick();                                       // t+3
    chk("rd_den_t3", dmi_en, 0);
    tick();                                       // t+4
    chk("rd_rv_t4", m0_rsp_valid, 1);
    chk("rd_rdata_t4", m0_rdata, 32'hDEADBEEF);
    chk("rd_err_t4", m0_error, 0);
    tick();                                       // t+5
    chk("rd_rv_t5", m0_rsp_valid, 0);
    chk("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);
    chk("rd_busy_t5", m0_busy, 0);

    // write on port 1 with busy stretched for 5 WAIT cycles
    clr_obs();
    dmi_rdata = 32'hCAFE0001;
    req(1, 7'h10, 32'h00000001, 1'b1);
    tick();
    for (int k = 1; k <= 9; k++) begin
      chk("wr_m1_busy", m1_busy, 1);
      chk("wr_rsp_valid", m1_rsp_valid, (k == 9));
      chk("wr_wen_eq_en", dmi_wen, dmi_en);
      if (k == 2) begin
        chk("wr_den", dmi_en, 1);
        chk("wr_wdata", dmi_wdata, 32'h1);
        chk("wr_addr", dmi_addr, 7'h10);
      end
      dmi_dm_busy = (k >= 2 && k <= 7);
      tick();
    end
    chk("wr_den_count", den_cnt, 1);
    chk("wr_m1_rdata", m1_rdata, 32'hCAFE0001);
    chk("wr_m1_busy_end", m1_busy, 0);

    // simultaneous requests after reset: port 0 then 1, then 1 then 0
    do_reset();
    clr_obs();
    dmi_dm_busy = 0;
    req(0, 7'h20, 32'hA0, 1'b0); req(1, 7'h21, 32'hA1, 1'b0);
    tick();
    chk("sim_no_ovr", {m1_overrun, m0_overrun}, 2'b00);
    for (int k = 0; k < 12; k++) tick();
    chk("sim1_count", iss.size(), 2);
    chk("sim1_first", iss[0], 7'h20);
    chk("sim1_second", iss[1], 7'h21);
    clr_obs();
    req(0, 7'h20, 32'hB0, 1'b1); req(1, 7'h21, 32'hB1, 1'b1);
    for (int k = 0; k < 13; k++) tick();
    chk("sim2_count", iss.size(), 2);
    chk("sim2_first", iss[0], 7'h21);
    chk("sim2_second", iss[1], 7'h20);

    // overrun: second port 0 pulse while the first is in service
    clr_obs();
    req(0, 7'h04, 32'h4, 1'b0);
    tick(); tick();
    req(0, 7'h05, 32'h5, 1'b0);
    tick();
    chk("ovr_pulse", m0_overrun, 1);
    for (int k = 0; k < 8; k++) tick();
    chk("ovr_issue_count", iss.size(), 1);
    chk("ovr_issue_addr", iss[0], 7'h04);
    chk("ovr_count", ovr_cnt[0], 1);
    chk("ovr_rsp_count", rv_cnt[0], 1);

    // reset while port 0 is in WAIT and port 1 is pending
    clr_obs();
    dmi_dm_busy = 1;
    req(0, 7'h30, 32'h30, 1'b0); req(1, 7'h31, 32'h31, 1'b0);
    tick(); tick(); tick();                       // now in WAIT
    chk("rst_m1_pending", m1_busy, 1);
    reset = 1;
    tick();
    chk_all_zero("midrst");
    reset = 0; dmi_dm_busy = 0;
    clr_obs();
    for (int k = 0; k < 10; k++) tick();
    chk("midrst_no_den", den_cnt, 0);
    chk("midrst_no_rsp", rv_cnt[0] + rv_cnt[1], 0);

`ifdef AIRI5C_DMI_ARB_TIMEOUT_EN
    // timeout: busy never falls during the window
    begin
      int rv_at;
      clr_obs();
      rv_at = -1;
      dmi_rdata = 32'h12345678; dmi_dm_busy = 1;
      req(0, 7'h07, 32'h0, 1'b0);
      tick();
      for (int k = 1; k <= 24; k++) begin
        if (m0_rsp_valid) begin
          rv_at = k;
          chk("to_err", m0_error, 1);
          chk("to_rdata", m0_rdata, 0);
        end
        if (k == 21) dmi_dm_busy = 0;             // late fall must be ignored
        tick();
      end
      chk("to_rv_cycle", rv_at, 4 + TO - 1);
      chk("to_rv_count", rv_cnt[0], 1);
      chk("to_idle", m0_busy, 0);
    end
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req(0, AW'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) req(1, AW'($urandom), $urandom, 1'($urandom));
      dmi_dm_busy = ($urandom_range(0, 2) != 0);
      dmi_rdata = $urandom;
      dmi_error = 1'($urandom);
      tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/airi5c_dmi_arbiter.md
Name: airi5c_dmi_arbiter

Overview:
- Shares the single Debug Module Interface (DMI) bus between two requesters.
- Port 0 is the JTAG debug transport module. Port 1 is a secondary debug bridge (e.g. UART/SoC-bus debug master).
- Captures one-cycle request pulses from each requester, grants them round-robin, and issues one DMI transaction at a time to the Debug Module.
- Waits for dmi_dm_busy to clear, then returns read data and error to the granted requester. Sits between the transport modules and the Debug Module.

Parameters:
- ADDR_W, 7, DMI address width (matches DMI_ADDR_WIDTH).
- DATA_W, 32, DMI data width (matches DMI_WIDTH).
- TIMEOUT_CYCLES, 1024, busy-wait limit, used only with the optional feature; minimum 2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- m0_en  in  1  port 0 request pulse (one cycle).
- m0_wen  in  1  port 0 write qualifier, valid with m0_en.
- m0_addr  in  ADDR_W  port 0 address, valid with m0_en.
- m0_wdata  in  DATA_W  port 0 write data, valid with m0_en.
- m0_rdata  out  DATA_W  port 0 response data; holds until next port 0 response.
- m0_error  out  1  port 0 response error; holds until next port 0 response.
- m0_rsp_valid  out  1  one-cycle pulse: port 0 response updated.
- m0_busy  out  1  port 0 request pending or in service.
- m0_overrun  out  1  one-cycle pulse: port 0 request dropped.
- m1_*  same set as m0_* for port 1.
- dmi_addr  out  ADDR_W  address to Debug Module.
- dmi_wdata  out  DATA_W  write data to Debug Module.
- dmi_en  out  1  one-cycle transaction strobe to Debug Module.
- dmi_wen  out  1  write strobe; asserted only together with dmi_en.
- dmi_rdata  in  DATA_W  Debug Module read data.
- dmi_error  in  1  Debug Module error.
- dmi_dm_busy  in  1  Debug Module still processing.

Behaviour:
- Reset: all outputs 0, state IDLE, pending flags clear, round-robin pointer set to port 0 priority.
- All outputs are registered.
- Capture:
  - mX_en=1 in cycle t with pendX=0 latches wen/addr/wdata and sets pendX at t+1.
  - mX_en=1 while pendX=1 or port X is in service drops the request, pulses mX_overrun at t+1 and leaves the latched request unchanged.
- mX_busy = pendX OR (port X granted and state != IDLE).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any pend flag is set, grant one port: single pending port wins; if both, the port the pointer favours wins.
  - On grant: clear that pend flag, load dmi_addr/dmi_wdata, go to ISSUE.
  - The pointer then favours the other port.
- ISSUE: dmi_en=1 for exactly this cycle; dmi_wen=latched wen; go to WAIT.
- WAIT:
  - If dmi_dm_busy=0, capture dmi_rdata and dmi_error into the granted port's response registers and go to RESP.
  - Otherwise stay in WAIT.
  - dmi_dm_busy is not examined in the ISSUE cycle.
- RESP: pulse mX_rsp_valid for the granted port; go to IDLE.
- dmi_addr/dmi_wdata hold their value after the transaction. dmi_en/dmi_wen are 0 in all states except ISSUE.
- Read transactions (wen=0) still drive dmi_wdata from the latched value.
- Write transactions still update mX_rdata/mX_error from the DMI response.
- Minimum latency: request pulse at t -> dmi_en at t+2 -> rsp_valid at t+4 (busy low at t+3).
- Back-to-back: a new request may be captured in the same cycle as its own port's rsp_valid; it is serviced from IDLE.
- Both ports pulsing in the same cycle: both are captured, serviced in pointer order, and no overrun occurs.
- reset asserted mid-transaction: immediate return to reset state; in-flight and pending requests are discarded and no response is issued.

Optional Feature:
- Macro: AIRI5C_DMI_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entering WAIT and increments each WAIT cycle with dmi_dm_busy=1.
  - At TIMEOUT_CYCLES, force a response: rdata=0, error=1, state RESP.
  - A later dmi_dm_busy fall for that transaction is ignored.
- When undefined: no counter; WAIT is unbounded.

Test Plan:
- Single read: m0 pulse addr=0x11 wen=0 at t; busy low; dmi_rdata=0xDEADBEEF -> dmi_en at t+2 with dmi_addr=0x11, dmi_wen=0; m0_rsp_valid at t+4; m0_rdata=0xDEADBEEF, m0_error=0.
- Write with busy stretch: m1 pulse addr=0x10 wdata=0x00000001 wen=1; dmi_dm_busy high 5 cycles after ISSUE -> dmi_en=dmi_wen=1 for exactly one cycle; m1_rsp_valid 1 cycle after busy falls; m1_busy high throughout.
- Simultaneous requests after reset: m0 and m1 pulse in the same cycle -> port 0 serviced first, then port 1. Repeat the same pair -> port 1 first.
- Overrun: m0 pulse addr=0x04, second m0 pulse addr=0x05 before its rsp_valid -> m0_overrun pulse; only addr 0x04 is issued.
- Reset mid-WAIT: assert reset during WAIT with m1 pending -> all outputs 0 next cycle; no rsp_valid and no further dmi_en after reset release.
- With AIRI5C_DMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: dmi_dm_busy held high -> m0_rsp_valid after 16 WAIT cycles with m0_error=1, m0_rdata=0; FSM back in IDLE.
